// File: rtl/param_mutex_pkg.sv
// ---------------------------------------------------------------------------
// param_mutex_pkg
// Shared definitions for the parametrised mutex arbiter:
//   - arbitration mode encodings (mode 3 is handled as plain round-robin)
//   - FSM state type (IDLE / OWNED)
//   - one-hot to index encoder used to derive grant_id from the grant vector
// ---------------------------------------------------------------------------
package param_mutex_pkg;

  localparam logic [1:0] MODE_FIXED = 2'd0;
  localparam logic [1:0] MODE_RR    = 2'd1;
  localparam logic [1:0] MODE_WRR   = 2'd2;

  // Largest supported requester count and the matching index width.
  localparam int MAX_N    = 16;
  localparam int MAX_ID_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  // OR-reduction encoder: exact for one-hot inputs, returns 0 for all-zero.
  function automatic logic [MAX_ID_W-1:0] onehot_to_idx(input logic [MAX_N-1:0] oh);
    logic [MAX_ID_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (oh[i]) idx = idx | MAX_ID_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/param_mutex_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// mutex_rr_pick
// Combinational rotating-priority picker.
//   req     : request vector
//   start   : first index examined in rotating mode (ascending, wraps N-1 -> 0)
//   fixed   : when high, ignore rotation and pick the highest asserted index
//   pick    : one-hot winner (all zero when no request)
//   pick_id : index of the winner (0 when none)
//   any     : high when a winner exists
// ---------------------------------------------------------------------------
module mutex_rr_pick
  import param_mutex_pkg::*;
#(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] start,
  input  logic            fixed,
  output logic [N-1:0]    pick,
  output logic [ID_W-1:0] pick_id,
  output logic            any
);

  always_comb begin
    pick    = '0;
    pick_id = '0;
    any     = 1'b0;
    if (fixed) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (req[i] && !any) begin
          pick[i] = 1'b1;
          pick_id = ID_W'(i);
          any     = 1'b1;
        end
      end
    end else begin
      // Walk offsets from start; the modulo keeps the search in range for
      // non-power-of-2 N.
      for (int off = 0; off < N; off++) begin
        for (int i = 0; i < N; i++) begin
          if (!any && req[i] && (i == ((int'(start) + off) % N))) begin
            pick[i] = 1'b1;
            pick_id = ID_W'(i);
            any     = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/param_mutex_arbiter.sv
// ---------------------------------------------------------------------------
// param_mutex_arbiter
// N-requester mutex with run-time selectable arbitration: fixed priority
// (highest index wins), round-robin, or weighted round-robin with
// per-requester burst lengths. Grants are registered and one-hot; lock[i]
// holds an existing grant for as long as req[i] stays high.
//   clk         : arbiter clock
//   rst         : asynchronous active-low reset
//   mode        : 0 fixed, 1 RR, 2 weighted RR, 3 RR
//   req/lock    : per-requester request and lock
//   weight      : flat array of WEIGHT_W-bit burst weights (0 behaves as 1)
//   grant       : registered one-hot grant
//   grant_valid : |grant
//   grant_id    : index of current owner, 0 when idle
//   rr_ptr      : current round-robin search start
// ---------------------------------------------------------------------------
module param_mutex_arbiter
  import param_mutex_pkg::*;
#(
  parameter int N        = 4,
  parameter int WEIGHT_W = 4,
  parameter int ID_W     = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            mode,
  input  logic [N-1:0]          req,
  input  logic [N-1:0]          lock,
  input  logic [N*WEIGHT_W-1:0] weight,
  output logic [N-1:0]          grant,
  output logic                  grant_valid,
  output logic [ID_W-1:0]       grant_id,
  output logic [ID_W-1:0]       rr_ptr
);

  state_t              r_state;
  logic [N-1:0]        r_grant;
  logic [ID_W-1:0]     r_rr_ptr;
  logic [WEIGHT_W-1:0] r_burst_cnt;

  logic [WEIGHT_W-1:0] w_own_weight;
  logic [WEIGHT_W-1:0] w_eff_weight;
  logic                w_burst_ok;
  logic                w_own_req;
  logic                w_own_lock;
  logic                w_stay;
  logic [N-1:0]        w_others;
  logic                w_rr_excl;
  logic [N-1:0]        w_arb_req;
  logic                w_fixed;
  logic [N-1:0]        w_pick;
  logic [ID_W-1:0]     w_pick_id;
  logic                w_any;
  logic [ID_W-1:0]     w_ptr_next;
  logic [MAX_N-1:0]    w_grant_ext;
  logic [MAX_ID_W-1:0] w_id_ext;

  // Weight of the current owner (zero when idle, which is harmless).
  always_comb begin
    w_own_weight = '0;
    for (int i = 0; i < N; i++) begin
      if (r_grant[i]) w_own_weight = weight[i*WEIGHT_W +: WEIGHT_W];
    end
  end

  assign w_eff_weight = (w_own_weight == '0) ? WEIGHT_W'(1) : w_own_weight;
  assign w_burst_ok   = (mode == MODE_WRR) && (r_burst_cnt < (w_eff_weight - WEIGHT_W'(1)));
  assign w_own_req    = |(req & r_grant);
  assign w_own_lock   = |(lock & r_grant);
  assign w_stay       = (r_state == OWNED) && w_own_req && (w_own_lock || w_burst_ok);

  // In rotating modes a releasing owner competes only if nobody else asks,
  // which makes it lowest priority even when rr_ptr went stale under mode 0.
  assign w_others  = req & ~r_grant;
  assign w_rr_excl = (r_state == OWNED) && (mode != MODE_FIXED) && (|w_others);
  assign w_arb_req = w_rr_excl ? w_others : req;
  assign w_fixed   = (mode == MODE_FIXED);

  mutex_rr_pick #(
    .N    (N),
    .ID_W (ID_W)
  ) u_pick (
    .req     (w_arb_req),
    .start   (r_rr_ptr),
    .fixed   (w_fixed),
    .pick    (w_pick),
    .pick_id (w_pick_id),
    .any     (w_any)
  );

  assign w_ptr_next = (w_pick_id == ID_W'(N - 1)) ? '0 : (w_pick_id + ID_W'(1));

  // Registered grant stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_grant     <= '0;
      r_rr_ptr    <= '0;
      r_burst_cnt <= '0;
    end else if (w_stay) begin
      // Saturate so a long lock cannot wrap into a fresh weighted burst.
      if (r_burst_cnt != '1) r_burst_cnt <= r_burst_cnt + WEIGHT_W'(1);
    end else if (w_any) begin
      r_state     <= OWNED;
      r_grant     <= w_pick;
      r_burst_cnt <= '0;
      if (!w_fixed) r_rr_ptr <= w_ptr_next;
    end else begin
      r_state     <= IDLE;
      r_grant     <= '0;
      r_burst_cnt <= '0;
    end
  end

  assign w_grant_ext = MAX_N'(r_grant);
  assign w_id_ext    = onehot_to_idx(w_grant_ext);

  assign grant       = r_grant;
  assign grant_valid = |r_grant;
  assign grant_id    = w_id_ext[ID_W-1:0];
  assign rr_ptr      = r_rr_ptr;

endmodule
